// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL lock-qualified reset sequencer.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // One shared counter serves every timed state, so it must hold the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Fewer than two stages gives no metastability settling time.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Holds the PLL in reset, qualifies lock, then releases downstream resets
// one at a time; any lock loss after release starts re-asserts everything.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int NUM_RESETS     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int STAGGER        = 16,
  parameter int TIMEOUT        = 65536,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  output logic                  pll_resetb,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  ready,
  output logic [CNT_W-1:0]      loss_count
);

  localparam int TMR_W = cnt_width(PLL_RST_CYCLES, LOCK_CYCLES, STAGGER, TIMEOUT);
  localparam int IDX_W = idx_width(NUM_RESETS);

  localparam logic [TMR_W-1:0] PLL_RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] STAGGER_LAST = TMR_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RESETS - 1);

  logic lock_s;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pll_resetb_q, pll_resetb_d;
  logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [CNT_W-1:0]      loss_q, loss_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pll_lock),
    .q       (lock_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    pll_resetb_d = pll_resetb_q;
    rst_out_d    = rst_out_q;
    ready_d      = ready_q;
    loss_d       = loss_q;

    case (state_q)
      PLLRST: begin
        pll_resetb_d = 1'b0;
        rst_out_d    = '1;
        ready_d      = 1'b0;
        if (cnt_q == PLL_RST_LAST) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          pll_resetb_d = 1'b1;
        end
      end

      // Lock is checked before the timeout so a lock on the final cycle wins.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = PLLRST;
          cnt_d        = '0;
          pll_resetb_d = 1'b0;
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d      = RELEASE;
          cnt_d        = '0;
          idx_d        = '0;
          rst_out_d[0] = 1'b0;
          if (NUM_RESETS == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end else if (cnt_q == STAGGER_LAST) begin
          cnt_d            = '0;
          idx_d            = idx_q + 1'b1;
          rst_out_d[idx_d] = 1'b0;
          if (idx_d == IDX_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end

      default: begin
        state_d      = PLLRST;
        cnt_d        = '0;
        pll_resetb_d = 1'b0;
        rst_out_d    = '1;
        ready_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= PLLRST;
      cnt_q        <= '0;
      idx_q        <= '0;
      pll_resetb_q <= 1'b0;
      rst_out_q    <= '1;
      ready_q      <= 1'b0;
      loss_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pll_resetb_q <= pll_resetb_d;
      rst_out_q    <= rst_out_d;
      ready_q      <= ready_d;
      loss_q       <= loss_d;
    end
  end

  assign pll_resetb = pll_resetb_q;
  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign loss_count = loss_q;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Lock-qualified reset sequencer for PLL-derived clocking on iCE40 boards.
- Sits beside the PLL primitive wrapper and runs on the board reference clock.
- Drives the PLL RESETB input and generates a staggered set of active-high resets once lock has been stable for a qualification window.
- Forces a PLL re-lock on timeout, re-asserts all resets on lock loss, and counts lock-loss events.

Parameters:
- NUM_RESETS, 3: number of reset outputs, released in index order 0..N-1
- SYNC_STAGES, 2: synchroniser depth for pll_lock (minimum 2)
- PLL_RST_CYCLES, 16: cycles pll_resetb is held low per PLL reset
- LOCK_CYCLES, 1024: consecutive cycles lock must be high before release
- STAGGER, 16: cycles between successive reset releases
- TIMEOUT, 65536: cycles waiting for lock before the PLL is reset again
- CNT_W, 8: width of the lock-loss counter

Ports:
- clock  in  1  board reference clock (not the PLL output)
- reset_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL LOCK, asynchronous to clock
- pll_resetb  out  1  to PLL RESETB; low means PLL held in reset
- rst_out  out  NUM_RESETS  active-high resets, one per downstream domain
- ready  out  1  high when all rst_out bits are released and lock is good
- loss_count  out  CNT_W  saturating count of lock losses after release began

Behaviour:
- Clock and reset (already decided): one clock, `clock`; reset `reset_n` is asynchronous and active-low.
- Reset values, while reset_n is low: state=PLLRST, counters 0, pll_resetb=0, rst_out=all 1, ready=0, loss_count=0, sync flops 0.
- Synchronisation: lock_s is pll_lock through SYNC_STAGES flops. The FSM uses lock_s only.
- PLLRST:
  - pll_resetb=0 for exactly PLL_RST_CYCLES cycles in this state, then go to WAIT_LOCK with pll_resetb=1.
  - rst_out stays all 1.
- WAIT_LOCK:
  - The counter increments each cycle.
  - If lock_s=1, go to STABLE with the counter cleared.
  - Else, if the counter reaches TIMEOUT-1, go to PLLRST (re-lock attempt).
  - If lock_s=1 on the timeout cycle, lock wins.
- STABLE:
  - lock_s=0 returns to WAIT_LOCK with the counter cleared; no loss_count change.
  - After LOCK_CYCLES consecutive high cycles, go to RELEASE with index=0.
- RELEASE:
  - On entry edge, rst_out[0] clears.
  - Every STAGGER cycles afterwards, the next index clears.
  - On the edge clearing rst_out[NUM_RESETS-1], ready goes to 1 and state goes to RUN.
  - With NUM_RESETS=1, release and ready occur on the same edge.
- RUN: holds until lock loss.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge: rst_out=all 1, ready=0, loss_count+1 (saturating at all ones), go to WAIT_LOCK.
  - Latency from the pll_lock falling edge to rst_out assertion is at most SYNC_STAGES+1 cycles.
- Monotonic release: rst_out bit i never clears while any bit j<i is set.
- ready=1 implies rst_out=0.
- A glitch of pll_lock shorter than one clock may be missed. This is acceptable.
- Mid-operation reset_n assertion: all outputs return to reset values immediately (asynchronously). loss_count clears.
- Counter widths: $clog2 of the largest of PLL_RST_CYCLES, LOCK_CYCLES, STAGGER, TIMEOUT; one shared down/up counter is permitted.

Decomposition:
- Package pll_reset_pkg:
  - FSM state enum (PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN)
  - localparam function for the counter width
  - index width $clog2(NUM_RESETS)
- Sub-module sync_bit:
  - Parametrised SYNC_STAGES flop chain with async active-low clear.
  - Instantiated once for pll_lock.

Test Plan (NUM_RESETS=3, SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_CYCLES=8, STAGGER=4, TIMEOUT=32, CNT_W=2):
1. reset_n low 3 cycles, then high; pll_lock tied 1 -> pll_resetb low exactly 4 cycles after release; rst_out[0] clears 8 cycles after STABLE entry; rst_out[1] clears 4 cycles later; rst_out[2] and ready=1 another 4 cycles later; loss_count=0.
2. pll_lock held 0 -> pll_resetb pulses low 4 cycles every 36 cycles (32 wait + 4 reset); rst_out stays 7, ready 0.
3. pll_lock high 5 cycles, low 1 cycle, then high, all during STABLE -> qualification restarts; rst_out[0] clears 8 cycles after lock_s returns high; loss_count=0.
4. In RUN, drop pll_lock -> rst_out=7 and ready=0 within 3 cycles; loss_count=1. Restore lock -> full staggered release repeats.
5. Drop lock during RELEASE after rst_out[0] cleared -> all bits reassert; loss_count increments. Four losses in total -> loss_count saturates at 3.
6. Assert reset_n low asynchronously mid-RUN, between clock edges -> rst_out=7, ready=0, pll_resetb=0, loss_count=0 immediately, without waiting for a clock edge.
